// File: rtl/regfile_pkg.sv
// Shared constants for the register-file / operand-decode block:
// reset defaults, instruction field positions and the idle opcode.
package regfile_pkg;

  localparam int TBL_DEPTH = 16;
  localparam int TBL_W     = 16;

  // Opcode presented on the output stage before the first capture.
  localparam logic [3:0] OPC_PLACEHOLDER = 4'h2;

  // Register contents loaded while reset is high.
  localparam logic [TBL_W-1:0] RST_TABLE [TBL_DEPTH] = '{
    16'h0000, 16'h0F00, 16'h0050, 16'hFF0F,
    16'hF0FF, 16'h0040, 16'h6666, 16'h00FF,
    16'hFF88, 16'h0000, 16'h0000, 16'h0000,
    16'hCCCC, 16'h0002, 16'h0000, 16'h0000
  };

  // Field layout: opcode in the top bits, rs1 directly below, rs2 below rs1.
  function automatic int opc_msb(input int instr_w);
    return instr_w - 1;
  endfunction

  function automatic int rs1_msb(input int instr_w, input int opc_w);
    return instr_w - opc_w - 1;
  endfunction

  function automatic int rs2_msb(input int instr_w, input int opc_w, input int addr_w);
    return instr_w - opc_w - addr_w - 1;
  endfunction

  // Entries past the end of the table come up as zero.
  function automatic logic [TBL_W-1:0] rst_value(input int idx);
    logic [3:0] idx4;
    idx4 = 4'(idx);
    if (idx >= 0 && idx < TBL_DEPTH) return RST_TABLE[idx4];
    return '0;
  endfunction

endpackage

// File: rtl/regfile_mem.sv
// Register storage: DEPTH x DATA_W, one synchronous write port and two
// asynchronous read ports, loaded from the package table during reset.
module regfile_mem
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_live;

  // Writes to register 0 are dropped when it is hard-wired to zero.
  assign wr_live = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // Next array contents: current contents with the write applied.
  always_comb begin
    mem_d = mem_q;
    if (wr_live) mem_d[wr_addr] = wr_data;
  end

  // Array state; reset loads the default table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(rst_value(i));
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_a = ((ZERO_REG != 0) && (rd_addr_a == '0)) ? '0 : mem_q[rd_addr_a];
  assign rd_data_b = ((ZERO_REG != 0) && (rd_addr_b == '0)) ? '0 : mem_q[rd_addr_b];

endmodule

// File: rtl/regfile_decode.sv
// Instruction decode with register-file operand fetch. One output stage
// with valid/ready handshake; same-cycle writes can forward into a capture,
// and writes always refresh operands held while the consumer stalls.
module regfile_decode
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int OPC_W    = 4,
  parameter int INSTR_W  = 16,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  op1,
  output logic [DATA_W-1:0]  op2,
  output logic [OPC_W-1:0]   opcode,
  output logic [ADDR_W-1:0]  rs1_q,
  output logic [ADDR_W-1:0]  rs2_q
);

  localparam int OPC_MSB = opc_msb(INSTR_W);
  localparam int RS1_MSB = rs1_msb(INSTR_W, OPC_W);
  localparam int RS2_MSB = rs2_msb(INSTR_W, OPC_W, ADDR_W);

  logic [OPC_W-1:0]  instr_opc;
  logic [ADDR_W-1:0] instr_rs1;
  logic [ADDR_W-1:0] instr_rs2;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;

  logic              out_valid_q, out_valid_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic [ADDR_W-1:0] rs1_d, rs2_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;

  logic wr_live;
  logic accept;
  logic stall;
  logic unused_instr_bits;

  assign instr_opc = instr[OPC_MSB -: OPC_W];
  assign instr_rs1 = instr[RS1_MSB -: ADDR_W];
  assign instr_rs2 = instr[RS2_MSB -: ADDR_W];

  // Bits below rs2 (if any) carry nothing for this stage.
  assign unused_instr_bits = ^instr;

  regfile_mem #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr_a(instr_rs1),
    .rd_data_a(rd_data_a),
    .rd_addr_b(instr_rs2),
    .rd_data_b(rd_data_b)
  );

  // A write to a hard-wired zero register must neither forward nor refresh.
  assign wr_live  = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign stall    = out_valid_q && !out_ready;

  // Output-stage next state: capture, refresh held operands, or drain.
  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    if (accept) begin
      out_valid_d = 1'b1;
      opcode_d    = instr_opc;
      rs1_d       = instr_rs1;
      rs2_d       = instr_rs2;
      op1_d       = ((BYPASS != 0) && wr_live && (wr_addr == instr_rs1)) ? wr_data : rd_data_a;
      op2_d       = ((BYPASS != 0) && wr_live && (wr_addr == instr_rs2)) ? wr_data : rd_data_b;
    end else if (stall) begin
      // Held operands track the register file so they never go stale.
      if (wr_live && (wr_addr == rs1_q)) op1_d = wr_data;
      if (wr_live && (wr_addr == rs2_q)) op2_d = wr_data;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Output-stage registers; reset discards any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      opcode_q    <= OPC_W'(OPC_PLACEHOLDER);
      rs1_q       <= '0;
      rs2_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign opcode    = opcode_q;
  assign op1       = op1_q;
  assign op2       = op2_q;

endmodule
